booth_mult_sched: RTL and testbench

Shared, sequential radix-4 Booth multiply engine with a round-robin front end. NREQ requesters each present a signed operand pair on a valid/ready channel. The scheduler grants one requester at a time, retires one Booth digit per clock, and returns the signed product tagged with the requester index on a valid/ready response channel. It sits between the arithmetic clients and the Booth recoding datapath, so a single adder can be time-shared instead of building one array per client.

---
 rtl/booth_pkg.sv | 41 ++++
 rtl/booth_pp_gen.sv | 41 ++++
 rtl/booth_mult_sched.sv | 149 ++++++++++++++
 tb/tb_booth_mult_sched.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : booth_pkg
//  Description : Shared types for the radix-4 Booth multiply scheduler:
//                FSM state encoding, Booth digit encoding and the
//                triplet-to-digit recoding function.
//  Revision    : 1.0 - initial release
// ============================================================================
package booth_pkg;

    // Scheduler states, explicitly 2 bits wide
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Radix-4 Booth digit values {-2,-1,0,+1,+2}
    typedef enum logic [2:0] {
        ZERO = 3'd0,
        P1   = 3'd1,
        P2   = 3'd2,
        M1   = 3'd3,
        M2   = 3'd4
    } digit_t;

    // Map a multiplier triplet {b[2k+1], b[2k], b[2k-1]} onto its Booth digit
    function automatic digit_t booth_recode(input logic [2:0] triplet);
        digit_t result;
        case (triplet)
            3'b001, 3'b010: result = P1;
            3'b011:         result = P2;
            3'b100:         result = M2;
            3'b101, 3'b110: result = M1;
            default:        result = ZERO;
        endcase
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/booth_pp_gen.sv
`default_nettype none
// ============================================================================
//  Module      : booth_pp_gen
//  Description : Combinational Booth partial-product generator. Recodes one
//                multiplier triplet, forms 0/+-a/+-2a at full product width
//                and shifts it into position for digit k.
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_pp_gen
    import booth_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int KW = $clog2(WIDTH / 2)
) (
    input  logic [WIDTH-1:0]   i_a,
    input  logic [2:0]         i_triplet,
    input  logic [KW-1:0]      i_k,
    output logic [2*WIDTH-1:0] o_pp
);

    logic [2*WIDTH-1:0] w_a_ext;
    logic [2*WIDTH-1:0] w_term;
    digit_t             w_digit;

    // Sign-extend a first so that -2a of the most negative operand is exact
    always_comb begin
        w_a_ext = {{WIDTH{i_a[WIDTH-1]}}, i_a};
        w_digit = booth_recode(i_triplet);
        w_term  = '0;
        case (w_digit)
            P1:      w_term = w_a_ext;
            P2:      w_term = w_a_ext << 1;
            M1:      w_term = -w_a_ext;
            M2:      w_term = -(w_a_ext << 1);
            default: w_term = '0;
        endcase
        o_pp = w_term << {i_k, 1'b0};
    end

endmodule
`default_nettype wire

// File: rtl/booth_mult_sched.sv
`default_nettype none
// ============================================================================
//  Module      : booth_mult_sched
//  Description : Round-robin front end feeding one sequential radix-4 Booth
//                multiplier. One requester is granted at a time, one Booth
//                digit is retired per clock, and the signed product is
//                returned tagged with the owning requester index.
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_mult_sched
    import booth_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 2,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [2*WIDTH-1:0]      rsp_product,
    output logic                    busy
);

    localparam int               c_KW     = $clog2(WIDTH / 2);
    localparam logic [c_KW-1:0]  c_K_LAST = c_KW'(WIDTH / 2 - 1);

    state_t               r_state;
    logic [IDW-1:0]       r_rr_ptr;
    logic [IDW-1:0]       r_id;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [2*WIDTH-1:0]   r_acc;
    logic [c_KW-1:0]      r_k;
    logic                 r_rsp_valid;
    logic                 r_busy;

    logic                 w_found;
    logic [IDW-1:0]       w_gnt_id;
    logic [WIDTH:0]       w_b_ext;
    logic [2:0]           w_triplet;
    logic [2*WIDTH-1:0]   w_pp;

    // Round-robin search: first valid requester at or after r_rr_ptr, wrapping
    always_comb begin
        w_found  = 1'b0;
        w_gnt_id = '0;
        for (int i = 0; i < NREQ; i++) begin
            int j;
            j = int'(r_rr_ptr) + i;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!w_found && req_valid[j]) begin
                w_found  = 1'b1;
                w_gnt_id = IDW'(j);
            end
        end
    end

    // Grant is only offered while idle, and only to the arbitration winner
    always_comb begin
        req_ready = '0;
        if (r_state == IDLE && w_found) begin
            req_ready[w_gnt_id] = 1'b1;
        end
    end

    // Current digit triplet; the appended zero supplies b[-1]
    always_comb begin
        w_b_ext   = {r_b, 1'b0};
        w_triplet = w_b_ext[{r_k, 1'b0} +: 3];
    end

    booth_pp_gen #(
        .WIDTH (WIDTH)
    ) u_pp_gen (
        .i_a       (r_a),
        .i_triplet (w_triplet),
        .i_k       (r_k),
        .o_pp      (w_pp)
    );

    // Scheduler FSM, accumulator and digit counter with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_id        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_k         <= '0;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_a     <= req_a[w_gnt_id * WIDTH +: WIDTH];
                        r_b     <= req_b[w_gnt_id * WIDTH +: WIDTH];
                        r_id    <= w_gnt_id;
                        r_acc   <= '0;
                        r_k     <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_acc <= r_acc + w_pp;
                    if (r_k == c_K_LAST) begin
                        r_k         <= '0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                        if (int'(r_id) == NREQ - 1) begin
                            r_rr_ptr <= '0;
                        end else begin
                            r_rr_ptr <= r_id + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid   = r_rsp_valid;
    assign rsp_product = r_acc;
    assign rsp_id      = r_id;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_booth_mult_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_booth_mult_sched
//  Description : Self-checking bench for booth_mult_sched (WIDTH=8, NREQ=3).
//                Directed steps followed by a randomized traffic phase checked
//                against per-requester queues of plain a*b products.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_mult_sched;

    localparam int WIDTH = 8;
    localparam int NREQ  = 3;
    localparam int IDW   = 2;
    localparam int N_OPS = 3000;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [2*WIDTH-1:0]    rsp_product;
    logic                  busy;

    int total;
    int bad;

    booth_mult_sched #(
        .WIDTH (WIDTH),
        .NREQ  (NREQ)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: two's complement product truncated to 2*WIDTH bits
    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic signed [15:0] sa;
        logic signed [15:0] sb;
        sa = $signed({{8{a[7]}}, a});
        sb = $signed({{8{b[7]}}, b});
        return 16'(sa * sb);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a request and return at the falling edge after its accept edge
    task automatic issue(input int id, input logic [7:0] a, input logic [7:0] b, input string tag);
        int cyc;
        req_a[id*8 +: 8] = a;
        req_b[id*8 +: 8] = b;
        req_valid[id]    = 1'b1;
        #1;
        cyc = 0;
        while (req_ready[id] !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_grant"}, 64'(req_ready), 64'(1) << id);
        @(posedge clk);
        @(negedge clk);
        req_valid[id] = 1'b0;
        chk({tag, "_busy"}, 64'(busy), 64'(1));
        chk({tag, "_rdy_low"}, 64'(req_ready), 64'(0));
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = 0;
        while (rsp_valid !== 1'b1 && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic do_op(input int id, input logic [7:0] a, input logic [7:0] b, input string tag);
        int cyc;
        rsp_ready = 1'b1;
        issue(id, a, b, tag);
        wait_rsp(cyc);
        chk({tag, "_latency"}, 64'(cyc), 64'(4));
        chk({tag, "_product"}, 64'(rsp_product), 64'(ref_mul(a, b)));
        chk({tag, "_id"}, 64'(rsp_id), 64'(id));
        @(negedge clk);
        chk({tag, "_consumed"}, 64'(rsp_valid), 64'(0));
        chk({tag, "_idle"}, 64'(busy), 64'(0));
    endtask

    logic [15:0] expq [NREQ][$];

    initial begin
        int          cyc;
        int          hits;
        int          acc_cnt;
        int          resp_cnt;
        int          cycles;
        logic [15:0] held_prod;
        logic [NREQ-1:0] vld;
        logic [7:0]  ra [NREQ];
        logic [7:0]  rb [NREQ];

        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_product", 64'(rsp_product), 64'(0));
        chk("rst_id", 64'(rsp_id), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("idle_req_ready", 64'(req_ready), 64'(0));

        // Basic multiply and signed corners
        do_op(0, 8'd3, 8'd5, "mul_3x5");
        do_op(1, 8'h80, 8'h80, "m128xm128");
        do_op(2, 8'h7F, 8'h80, "p127xm128");
        do_op(0, 8'hFF, 8'hFF, "m1xm1");
        do_op(1, 8'h00, 8'hB3, "0xm77");

        // Back-pressure in DONE with a request waiting behind it
        rsp_ready = 1'b0;
        issue(2, 8'h25, 8'hE3, "hold");
        req_a[7:0] = 8'h5A;
        req_b[7:0] = 8'hC1;
        req_valid[0] = 1'b1;
        wait_rsp(cyc);
        chk("hold_latency", 64'(cyc), 64'(4));
        held_prod = ref_mul(8'h25, 8'hE3);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            chk("hold_valid", 64'(rsp_valid), 64'(1));
            chk("hold_product", 64'(rsp_product), 64'(held_prod));
            chk("hold_id", 64'(rsp_id), 64'(2));
            chk("hold_rdy_low", 64'(req_ready), 64'(0));
            chk("hold_busy", 64'(busy), 64'(1));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("hold_released", 64'(rsp_valid), 64'(0));
        chk("hold_wrap_grant", 64'(req_ready), 64'(1));
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        wait_rsp(cyc);
        chk("hold_next_latency", 64'(cyc), 64'(4));
        chk("hold_next_product", 64'(rsp_product), 64'(ref_mul(8'h5A, 8'hC1)));
        chk("hold_next_id", 64'(rsp_id), 64'(0));
        @(negedge clk);

        // Reset in the middle of RUN discards the operation
        issue(1, 8'h4D, 8'h9B, "abort");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_product", 64'(rsp_product), 64'(0));
        chk("abort_id", 64'(rsp_id), 64'(0));
        chk("abort_req_ready", 64'(req_ready), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        hits = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) hits++;
        end
        chk("abort_no_rsp", 64'(hits), 64'(0));
        do_op(0, 8'd6, 8'hF9, "after_abort");
        chk("after_abort_value", 64'(ref_mul(8'd6, 8'hF9)), 64'(16'hFFD6));

        // Constant contention from requesters 0 and 1: strict alternation
        req_a[7:0]  = 8'h91; req_b[7:0]  = 8'h3C;
        req_a[15:8] = 8'h6E; req_b[15:8] = 8'hA7;
        req_valid   = 3'b011;
        rsp_ready   = 1'b1;
        for (int n = 0; n < 6; n++) begin
            int exp_id;
            exp_id = (n % 2 == 0) ? 1 : 0;
            wait_rsp(cyc);
            chk("rr_wait", 64'(cyc < 30), 64'(1));
            chk("rr_id", 64'(rsp_id), 64'(exp_id));
            chk("rr_product", 64'(rsp_product),
                64'((exp_id == 0) ? ref_mul(8'h91, 8'h3C) : ref_mul(8'h6E, 8'hA7)));
            if (n == 5) req_valid = '0;
            @(negedge clk);
        end
        @(negedge clk);

        // Randomized traffic against per-requester expectation queues
        acc_cnt  = 0;
        resp_cnt = 0;
        cycles   = 0;
        vld      = '0;
        while (!(acc_cnt >= N_OPS && resp_cnt == acc_cnt) && cycles < 60000) begin
            for (int i = 0; i < NREQ; i++) begin
                if (vld[i]) begin
                    if ($urandom_range(7) == 0) vld[i] = 1'b0;
                end else if (acc_cnt < N_OPS && $urandom_range(2) == 0) begin
                    vld[i] = 1'b1;
                    ra[i]  = 8'($urandom);
                    rb[i]  = 8'($urandom);
                    if ($urandom_range(9) == 0) ra[i] = 8'h80;
                    if ($urandom_range(9) == 0) rb[i] = 8'h80;
                    req_a[i*8 +: 8] = ra[i];
                    req_b[i*8 +: 8] = rb[i];
                end
            end
            if (acc_cnt >= N_OPS) vld = '0;
            req_valid = vld;
            rsp_ready = ($urandom_range(3) != 0);
            #1;
            chk("rand_onehot", 64'($countones(req_ready) <= 1), 64'(1));
            chk("rand_rdy_valid", 64'(req_ready & ~req_valid), 64'(0));
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i] && req_valid[i]) begin
                    expq[i].push_back(ref_mul(ra[i], rb[i]));
                    acc_cnt++;
                    vld[i] = 1'b0;
                end
            end
            if (rsp_valid && rsp_ready) begin
                chk("rand_id_range", 64'(rsp_id < NREQ), 64'(1));
                if (rsp_id < NREQ) begin
                    chk("rand_pending", 64'(expq[rsp_id].size() > 0), 64'(1));
                    if (expq[rsp_id].size() > 0) begin
                        chk("rand_product", 64'(rsp_product), 64'(expq[rsp_id].pop_front()));
                    end
                end
                resp_cnt++;
            end
            @(negedge clk);
            cycles++;
        end
        req_valid = '0;
        chk("rand_timeout", 64'(cycles < 60000), 64'(1));
        chk("rand_all_answered", 64'(resp_cnt), 64'(acc_cnt));
        chk("rand_q0_empty", 64'(expq[0].size()), 64'(0));
        chk("rand_q1_empty", 64'(expq[1].size()), 64'(0));
        chk("rand_q2_empty", 64'(expq[2].size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
